// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with glitch rejection,
// parity, framing and break detection.
module uart_rx_param #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY     = 0
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic            o_rx_done_tick,
    output logic [DBIT-1:0] o_data,
    output logic            o_parity_err,
    output logic            o_frame_err,
    output logic            o_break
);

    localparam int SMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_bit_q, par_bit_d;
    logic            stop_ok_q, stop_ok_d;
    logic            sync1_q, rx_s_q;
    logic            done_q, done_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            brk_q, brk_d;

    logic stop_now;
    logic xor_all;
    logic par_err;

    assign xor_all = (^b_q) ^ par_bit_q;

    always_comb begin
        par_err = 1'b0;
        if (PARITY == 1) par_err = ~xor_all;
        if (PARITY == 2) par_err = xor_all;
    end

    // With SB_TICK == OVERSAMPLE the stop sample and completion share a tick
    assign stop_now = (s_q == S_BIT) ? rx_s_q : stop_ok_q;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        par_bit_d = par_bit_q;
        stop_ok_d = stop_ok_q;
        done_d    = 1'b0;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        brk_d     = brk_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s_q == S_HALF) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            s_d       = '0;
                            n_d       = '0;
                            par_bit_d = 1'b0;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PAR: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT) begin
                        par_bit_d = rx_s_q;
                        state_d   = STOP;
                        s_d       = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT) stop_ok_d = rx_s_q;
                    if (s_q == S_STOP) begin
                        done_d  = 1'b1;
                        data_d  = b_q;
                        perr_d  = par_err;
                        ferr_d  = ~stop_now;
                        brk_d   = ~stop_now && (b_q == '0) && !par_bit_q;
                        state_d = stop_now ? IDLE : RECOVER;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            RECOVER: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            par_bit_q <= 1'b0;
            stop_ok_q <= 1'b0;
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            done_q    <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            par_bit_q <= par_bit_d;
            stop_ok_q <= stop_ok_d;
            sync1_q   <= i_rx;
            rx_s_q    <= sync1_q;
            done_q    <= done_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
        end
    end

    assign o_rx_done_tick = done_q;
    assign o_data         = data_q;
    assign o_parity_err   = perr_q;
    assign o_frame_err    = ferr_q;
    assign o_break        = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 7E1 and 8N2 instances
// driven with hand-built serial frames.
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // one tick every 4 clocks, 64 clocks per bit at OVERSAMPLE=16
    logic [1:0] tcnt = 2'd0;
    logic       tick;
    always @(posedge clk) tcnt <= tcnt + 2'd1;
    assign tick = (tcnt == 2'd3);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rx [3];
    logic rst [3];

    logic       done_a, perr_a, ferr_a, brk_a;
    logic [7:0] data_a;
    logic       done_b, perr_b, ferr_b, brk_b;
    logic [6:0] data_b;
    logic       done_c, perr_c, ferr_c, brk_c;
    logic [7:0] data_c;

    uart_rx_param #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(0)) dut_a (
        .i_clock(clk), .i_reset(rst[0]), .i_rx(rx[0]), .i_s_tick(tick),
        .o_rx_done_tick(done_a), .o_data(data_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_break(brk_a)
    );

    uart_rx_param #(.DBIT(7), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(2)) dut_b (
        .i_clock(clk), .i_reset(rst[1]), .i_rx(rx[1]), .i_s_tick(tick),
        .o_rx_done_tick(done_b), .o_data(data_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_break(brk_b)
    );

    uart_rx_param #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(32), .PARITY(0)) dut_c (
        .i_clock(clk), .i_reset(rst[2]), .i_rx(rx[2]), .i_s_tick(tick),
        .o_rx_done_tick(done_c), .o_data(data_c), .o_parity_err(perr_c),
        .o_frame_err(ferr_c), .o_break(brk_c)
    );

    int na = 0, nb = 0, nc = 0;
    int tc0 = 0, tc1 = 0;
    always @(posedge clk) begin
        if (done_a) na <= na + 1;
        if (done_b) nb <= nb + 1;
        if (done_c) begin
            nc  <= nc + 1;
            tc0 <= cyc;
            tc1 <= tc0;
        end
    end

    // outputs of instance A may only move together with done (or reset)
    int         viol = 0;
    logic [10:0] prev_v = '0;
    always @(posedge clk) begin
        #1;
        if (!rst[0] && !done_a && {data_a, perr_a, ferr_a, brk_a} != prev_v)
            viol = viol + 1;
        prev_v = {data_a, perr_a, ferr_a, brk_a};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bits(input int n);
        repeat (n * 64) @(negedge clk);
    endtask

    task automatic send(input int d, input logic [8:0] v, input int nbits,
                        input bit par_en, input logic par, input int nstop);
        rx[d] = 1'b0;
        bits(1);
        for (int i = 0; i < nbits; i++) begin
            rx[d] = v[i];
            bits(1);
        end
        if (par_en) begin
            rx[d] = par;
            bits(1);
        end
        rx[d] = 1'b1;
        bits(nstop);
    endtask

    int n0;
    logic [7:0] v3c;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx[i]  = 1'b1;
            rst[i] = 1'b1;
        end
        repeat (4) @(negedge clk);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_data", {24'd0, data_a}, 32'd0);
        chk("rst_perr", {31'd0, perr_a}, 32'd0);
        chk("rst_ferr", {31'd0, ferr_a}, 32'd0);
        chk("rst_brk", {31'd0, brk_a}, 32'd0);
        chk("rst_data_b", {25'd0, data_b}, 32'd0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        bits(2);

        // 8N1 0xA5
        n0 = na;
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1);
        bits(1);
        chk("a5_count", na - n0, 32'd1);
        chk("a5_data", {24'd0, data_a}, 32'hA5);
        chk("a5_perr", {31'd0, perr_a}, 32'd0);
        chk("a5_ferr", {31'd0, ferr_a}, 32'd0);
        chk("a5_brk", {31'd0, brk_a}, 32'd0);

        // 5-tick low glitch
        n0 = na;
        rx[0] = 1'b0;
        repeat (20) @(negedge clk);
        rx[0] = 1'b1;
        bits(2);
        chk("glitch_count", na - n0, 32'd0);
        chk("glitch_data", {24'd0, data_a}, 32'hA5);
        chk("glitch_ferr", {31'd0, ferr_a}, 32'd0);

        // 7E1 0x41: good parity, then bad parity
        send(1, 9'h041, 7, 1'b1, 1'b0, 1);
        bits(1);
        chk("par_ok_count", nb, 32'd1);
        chk("par_ok_data", {25'd0, data_b}, 32'h41);
        chk("par_ok_perr", {31'd0, perr_b}, 32'd0);
        send(1, 9'h041, 7, 1'b1, 1'b1, 1);
        bits(1);
        chk("par_bad_count", nb, 32'd2);
        chk("par_bad_data", {25'd0, data_b}, 32'h41);
        chk("par_bad_perr", {31'd0, perr_b}, 32'd1);
        chk("par_bad_ferr", {31'd0, ferr_b}, 32'd0);
        chk("par_bad_brk", {31'd0, brk_b}, 32'd0);

        // break: low for 3 frame times
        n0 = na;
        rx[0] = 1'b0;
        bits(29);
        chk("brk_count", na - n0, 32'd1);
        chk("brk_data", {24'd0, data_a}, 32'd0);
        chk("brk_ferr", {31'd0, ferr_a}, 32'd1);
        chk("brk_flag", {31'd0, brk_a}, 32'd1);
        chk("brk_perr", {31'd0, perr_a}, 32'd0);
        bits(1);
        rx[0] = 1'b1;
        bits(2);
        chk("brk_release_count", na - n0, 32'd1);
        send(0, 9'h055, 8, 1'b0, 1'b0, 1);
        bits(1);
        chk("after_brk_count", na - n0, 32'd2);
        chk("after_brk_data", {24'd0, data_a}, 32'h55);
        chk("after_brk_ferr", {31'd0, ferr_a}, 32'd0);
        chk("after_brk_brk", {31'd0, brk_a}, 32'd0);

        // 8N2 back-to-back 0x00, 0xFF
        send(2, 9'h000, 8, 1'b0, 1'b0, 2);
        chk("b2b_first_count", nc, 32'd1);
        chk("b2b_first_data", {24'd0, data_c}, 32'h00);
        chk("b2b_first_ferr", {31'd0, ferr_c}, 32'd0);
        send(2, 9'h0FF, 8, 1'b0, 1'b0, 2);
        bits(1);
        chk("b2b_count", nc, 32'd2);
        chk("b2b_data", {24'd0, data_c}, 32'hFF);
        chk("b2b_ferr", {31'd0, ferr_c}, 32'd0);
        chk("b2b_spacing", tc0 - tc1, 32'd704);

        // reset pulse during 4th data bit of 0x3C
        v3c = 8'h3C;
        n0 = na;
        rx[0] = 1'b0;
        bits(1);
        for (int i = 0; i < 3; i++) begin
            rx[0] = v3c[i];
            bits(1);
        end
        rx[0] = v3c[3];
        repeat (32) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("mrst_done", {31'd0, done_a}, 32'd0);
        chk("mrst_data", {24'd0, data_a}, 32'd0);
        chk("mrst_ferr", {31'd0, ferr_a}, 32'd0);
        chk("mrst_brk", {31'd0, brk_a}, 32'd0);
        repeat (31) @(negedge clk);
        for (int i = 4; i < 8; i++) begin
            rx[0] = v3c[i];
            bits(1);
        end
        rx[0] = 1'b1;
        bits(1);
        chk("mrst_count", na - n0, 32'd0);
        bits(12);
        n0 = na;
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1);
        bits(1);
        chk("post_rst_count", na - n0, 32'd1);
        chk("post_rst_data", {24'd0, data_a}, 32'h3C);
        chk("post_rst_ferr", {31'd0, ferr_a}, 32'd0);

        chk("outputs_stable", viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
